// File: rtl/sync_flag_filter_pkg.sv
// Shared constants for the flag glitch filter: FSM state encodings and the
// filter run-length counter width.
package sync_flag_filter_pkg;

  localparam int FILT_CNT_W = 8;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHECK_HI  = 2'b01,
    STABLE_HI = 2'b10,
    CHECK_LO  = 2'b11
  } filt_state_e;

endpackage

// File: rtl/sync_flag_filter_sat_event_counter.sv
// Saturating event counter with a sticky overflow flag and synchronous clear.
// Clear has priority over a coincident increment.
module sat_event_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
      if (&cnt) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_flag_filter.sv
// Glitch filter for an already-synchronized flag: a level change is accepted
// after FILTER_CYCLES consecutive equal samples; edges are counted saturating.
module sync_flag_filter
  import sync_flag_filter_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 IN,
  input  logic                 CLR,
  output logic                 FILT_OUT,
  output logic                 RISE,
  output logic                 FALL,
  output logic [CNT_WIDTH-1:0] EVENT_CNT,
  output logic                 OVERFLOW
);

  localparam logic [FILT_CNT_W-1:0] FC    = FILT_CNT_W'(FILTER_CYCLES);
  localparam logic                  F_ONE = (FILTER_CYCLES == 1);

  logic                  in_q;
  filt_state_e           state;
  logic [FILT_CNT_W-1:0] filt_cnt;
  logic [FILT_CNT_W-1:0] filt_cnt_inc;

  assign filt_cnt_inc = filt_cnt + FILT_CNT_W'(1);

  // Stage 0: single input register, the only consumer of IN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_q <= 1'b0;
    end else begin
      in_q <= IN;
    end
  end

  // Stage 1: run-length FSM with registered level and edge pulses
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= STABLE_LO;
      filt_cnt <= '0;
      FILT_OUT <= 1'b0;
      RISE     <= 1'b0;
      FALL     <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      unique case (state)
        STABLE_LO: begin
          if (in_q) begin
            filt_cnt <= FILT_CNT_W'(1);
            if (F_ONE) begin
              state    <= STABLE_HI;
              FILT_OUT <= 1'b1;
              RISE     <= 1'b1;
            end else begin
              state <= CHECK_HI;
            end
          end
        end
        CHECK_HI: begin
          if (!in_q) begin
            state    <= STABLE_LO;
            filt_cnt <= '0;
          end else if (filt_cnt_inc == FC) begin
            state    <= STABLE_HI;
            filt_cnt <= '0;
            FILT_OUT <= 1'b1;
            RISE     <= 1'b1;
          end else begin
            filt_cnt <= filt_cnt_inc;
          end
        end
        STABLE_HI: begin
          if (!in_q) begin
            filt_cnt <= FILT_CNT_W'(1);
            if (F_ONE) begin
              state    <= STABLE_LO;
              FILT_OUT <= 1'b0;
              FALL     <= 1'b1;
            end else begin
              state <= CHECK_LO;
            end
          end
        end
        CHECK_LO: begin
          if (in_q) begin
            state    <= STABLE_HI;
            filt_cnt <= '0;
          end else if (filt_cnt_inc == FC) begin
            state    <= STABLE_LO;
            filt_cnt <= '0;
            FILT_OUT <= 1'b0;
            FALL     <= 1'b1;
          end else begin
            filt_cnt <= filt_cnt_inc;
          end
        end
        default: begin
          state    <= STABLE_LO;
          filt_cnt <= '0;
          FILT_OUT <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: event count follows the registered RISE pulse
  sat_event_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_evt_cnt (
    .clk  (CLK),
    .rst_n(RESET_N),
    .clr  (CLR),
    .inc  (RISE),
    .cnt  (EVENT_CNT),
    .ovf  (OVERFLOW)
  );

endmodule

// File: tb/tb_sync_flag_filter.sv
// Bench for sync_flag_filter: two instances (FILTER_CYCLES=4 and =1, 4-bit
// counters) against a run-length reference model, directed then random.
module tb_sync_flag_filter;

  logic       clk;
  logic       rst_n;
  logic       in4;
  logic       in1;
  logic       clr;
  logic [1:0] filt_o;
  logic [1:0] rise_o;
  logic [1:0] fall_o;
  logic [1:0] ovf_o;
  logic [3:0] cnt_o [2];

  int vectors = 0;
  int errors  = 0;

  // Reference model state per instance
  int   fc [2] = '{4, 1};
  logic m_inq  [2];
  logic m_filt [2];
  logic m_rise [2];
  logic m_fall [2];
  logic m_ovf  [2];
  int   m_cnt  [2];
  int   m_run  [2];

  sync_flag_filter #(.FILTER_CYCLES(4), .CNT_WIDTH(4)) dut4 (
    .CLK(clk), .RESET_N(rst_n), .IN(in4), .CLR(clr),
    .FILT_OUT(filt_o[0]), .RISE(rise_o[0]), .FALL(fall_o[0]),
    .EVENT_CNT(cnt_o[0]), .OVERFLOW(ovf_o[0])
  );

  sync_flag_filter #(.FILTER_CYCLES(1), .CNT_WIDTH(4)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .IN(in1), .CLR(clr),
    .FILT_OUT(filt_o[1]), .RISE(rise_o[1]), .FALL(fall_o[1]),
    .EVENT_CNT(cnt_o[1]), .OVERFLOW(ovf_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_inq[i] = 0; m_filt[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      m_ovf[i] = 0; m_cnt[i] = 0; m_run[i] = 0;
    end
  endtask

  // One clock edge: a level flips once fc consecutive registered samples differ from it
  task automatic model_edge(input int i, input logic in_now, input logic clr_now);
    if (clr_now) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
    end else if (m_rise[i]) begin
      if (m_cnt[i] == 15) m_ovf[i] = 1;
      else m_cnt[i] = m_cnt[i] + 1;
    end
    m_rise[i] = 0;
    m_fall[i] = 0;
    if (m_inq[i] != m_filt[i]) begin
      m_run[i] = m_run[i] + 1;
      if (m_run[i] == fc[i]) begin
        m_filt[i] = !m_filt[i];
        m_run[i]  = 0;
        if (m_filt[i]) m_rise[i] = 1;
        else m_fall[i] = 1;
      end
    end else begin
      m_run[i] = 0;
    end
    m_inq[i] = in_now;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("filt_out[%0d]", i), 32'(filt_o[i]), 32'(m_filt[i]));
      check($sformatf("rise[%0d]", i), 32'(rise_o[i]), 32'(m_rise[i]));
      check($sformatf("fall[%0d]", i), 32'(fall_o[i]), 32'(m_fall[i]));
      check($sformatf("event_cnt[%0d]", i), 32'(cnt_o[i]), 32'(m_cnt[i]));
      check($sformatf("overflow[%0d]", i), 32'(ovf_o[i]), 32'(m_ovf[i]));
      check($sformatf("rise_fall_excl[%0d]", i), 32'(rise_o[i] & fall_o[i]), 32'(0));
    end
  endtask

  task automatic step(input logic a4, input logic a1, input logic c);
    in4 = a4;
    in1 = a1;
    clr = c;
    @(posedge clk);
    model_edge(0, a4, c);
    model_edge(1, a1, c);
    #1;
    check_all();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic lvl;
    logic prev_a1;
    logic a1;
    int   len;

    rst_n = 1'b0;
    in4 = 1'b0;
    in1 = 1'b0;
    clr = 1'b0;
    model_reset();
    #3;
    check_all();
    #5;
    rst_n = 1'b1;

    // Short high run is rejected
    repeat (3) step(1, 1, 0);
    repeat (5) begin
      step(0, 0, 0);
      check("short_run_filt", 32'(filt_o[0]), 32'(0));
      check("short_run_rise", 32'(rise_o[0]), 32'(0));
    end
    check("short_run_cnt", 32'(cnt_o[0]), 32'(0));

    // Accepted rise: latency of four samples
    for (int k = 1; k <= 6; k++) begin
      step(1, 1, 0);
      if (k == 4) check("lat_filt_before", 32'(filt_o[0]), 32'(0));
      if (k == 5) begin
        check("lat_filt_after", 32'(filt_o[0]), 32'(1));
        check("lat_rise", 32'(rise_o[0]), 32'(1));
      end
      if (k == 6) begin
        check("lat_rise_one_cycle", 32'(rise_o[0]), 32'(0));
        check("lat_cnt", 32'(cnt_o[0]), 32'(1));
      end
    end
    repeat (5) step(0, 0, 0);
    step(0, 0, 1);

    // Seventeen accepted events: saturation and sticky overflow
    for (int e = 1; e <= 17; e++) begin
      repeat (5) step(1, 1, 0);
      repeat (5) step(0, 0, 0);
      if (e == 15) begin
        check("sat15_cnt", 32'(cnt_o[0]), 32'(15));
        check("sat15_ovf", 32'(ovf_o[0]), 32'(0));
      end
      if (e >= 16) begin
        check("sat_cnt", 32'(cnt_o[0]), 32'(15));
        check("sat_ovf", 32'(ovf_o[0]), 32'(1));
      end
    end
    step(0, 0, 1);
    check("clr_cnt", 32'(cnt_o[0]), 32'(0));
    check("clr_ovf", 32'(ovf_o[0]), 32'(0));

    // Clear coincident with the increment wins
    repeat (5) step(1, 1, 0);
    check("clr_race_rise", 32'(rise_o[0]), 32'(1));
    step(1, 1, 1);
    check("clr_race_cnt", 32'(cnt_o[0]), 32'(0));
    check("clr_race_ovf", 32'(ovf_o[0]), 32'(0));
    step(1, 1, 0);
    check("clr_race_lost", 32'(cnt_o[0]), 32'(0));
    repeat (5) step(0, 0, 0);

    // Reset during a pending check, released with IN high
    step(1, 1, 0);
    step(1, 1, 0);
    reset_pulse();
    check("rst_filt", 32'(filt_o[0]), 32'(0));
    for (int k = 1; k <= 6; k++) begin
      step(1, 1, 0);
      if (k == 4) check("rst_rel_filt_before", 32'(filt_o[0]), 32'(0));
      if (k == 5) begin
        check("rst_rel_filt_after", 32'(filt_o[0]), 32'(1));
        check("rst_rel_rise", 32'(rise_o[0]), 32'(1));
      end
      if (k == 6) check("rst_rel_cnt", 32'(cnt_o[0]), 32'(1));
    end

    // FILTER_CYCLES=1 instance with IN toggling every cycle
    step(0, 0, 0);
    step(0, 0, 0);
    prev_a1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      a1 = (k % 2 == 0);
      step(0, a1, 0);
      check("toggle_follow", 32'(filt_o[1]), 32'(prev_a1));
      prev_a1 = a1;
    end

    // Random bursts of varying length, occasional clear and one reset
    for (int n = 0; n < 60; n++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        step(lvl, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      end
      if (n == 30) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sync_flag_filter.md
SYNC_FLAG_FILTER -- requirements
Module: sync_flag_filter

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 4: consecutive equal samples required to accept a level change (legal range 1..255).
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the rising-event counter (legal range 2..32).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 RESET_N  input  1  asynchronous active-low reset.
REQ-006 IN  input  1  flag level, already synchronized into the CLK domain upstream.
REQ-007 CLR  input  1  synchronous clear of EVENT_CNT and OVERFLOW.
REQ-008 FILT_OUT  output  1  glitch-filtered level.
REQ-009 RISE  output  1  one-cycle pulse on the FILT_OUT 0->1 transition.
REQ-010 FALL  output  1  one-cycle pulse on the FILT_OUT 1->0 transition.
REQ-011 EVENT_CNT  output  CNT_WIDTH  saturating count of RISE pulses.
REQ-012 OVERFLOW  output  1  sticky flag, set when a RISE occurs while EVENT_CNT is saturated.

Function
REQ-013 IN SHALL be registered once into in_q; no other logic SHALL use IN directly.
REQ-014 The FSM SHALL have four states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-015 The filter counter SHALL be 8 bits wide.
REQ-016 In STABLE_LO with in_q=1, the counter SHALL load 1; the FSM SHALL go to STABLE_HI if FILTER_CYCLES=1, otherwise to CHECK_HI.
REQ-017 In CHECK_HI with in_q=1, the counter SHALL increment; on reaching FILTER_CYCLES the FSM SHALL go to STABLE_HI.
REQ-018 In CHECK_HI with in_q=0, the FSM SHALL return to STABLE_LO and clear the counter, with no output change.
REQ-019 STABLE_HI and CHECK_LO SHALL mirror REQ-016..018 with the polarity inverted.
REQ-020 Latency: if IN is sampled at the new value at edges e0..e0+FILTER_CYCLES-1, FILT_OUT SHALL change at edge e0+FILTER_CYCLES.
REQ-021 A run of fewer than FILTER_CYCLES equal samples SHALL be rejected with no output change.
REQ-022 FILT_OUT SHALL be registered and SHALL equal 1 exactly in STABLE_HI and CHECK_LO.
REQ-023 RISE and FALL SHALL be registered and high for exactly the one cycle following the FILT_OUT transition; they SHALL never be high together.
REQ-024 On RISE, EVENT_CNT SHALL increment by 1, stopping at all-ones with no wrap.
REQ-025 A RISE at all-ones SHALL set OVERFLOW and leave EVENT_CNT at all-ones.
REQ-026 CLR SHALL zero EVENT_CNT and OVERFLOW at the next edge; CLR coincident with a RISE increment SHALL win, leaving EVENT_CNT=0 and the event lost.
REQ-027 CLR SHALL NOT affect the FSM, FILT_OUT, RISE or FALL.

Reset
REQ-028 While RESET_N=0, in_q, FILT_OUT, RISE, FALL, EVENT_CNT, OVERFLOW and the filter counter SHALL all be 0, and the FSM SHALL be in STABLE_LO, all independent of CLK.
REQ-029 Reset asserted mid-CHECK SHALL abort the check with no pulse emitted.
REQ-030 If IN=1 at reset release, the block SHALL treat it as a normal rising change: FILT_OUT=1, a RISE pulse, and EVENT_CNT=1 after REQ-020 latency.

Structure
REQ-031 FSM state encodings and the filter-counter width SHALL live in the shared project constants include, not be local to this module.
REQ-032 The saturating event counter with sticky overflow SHALL be a sub-module named sat_event_counter, parameterized by CNT_WIDTH.
REQ-033 The FSM and filter counter SHALL be in the top module.

Verification (FILTER_CYCLES=4, CNT_WIDTH=4 unless stated)
REQ-034 IN high for 3 cycles then low -> FILT_OUT stays 0; RISE never asserts; EVENT_CNT=0.
REQ-035 IN rising and sampled at edge e0, then held -> FILT_OUT=1 at e0+4; RISE high one cycle; EVENT_CNT=1.
REQ-036 17 accepted rising events -> EVENT_CNT=15 from the 15th onward; OVERFLOW=1 after the 16th; CLR -> both 0 next edge.
REQ-037 CLR in the same cycle as a RISE increment -> EVENT_CNT=0, OVERFLOW=0.
REQ-038 RESET_N pulsed low during CHECK_HI -> all outputs 0 immediately; FILT_OUT 0 after release until 4 new stable samples.
REQ-039 FILTER_CYCLES=1, IN toggling every cycle -> FILT_OUT follows IN delayed 2 edges; alternating RISE/FALL pulses; EVENT_CNT counts every rise.
